// File: rtl/ledtest_pkg.sv
// Shared types and constants for the PIO LED blink master.
// FSM encoding, default PIO register address and bus data width.
package ledtest_pkg;

  localparam int DATA_W = 32;
  localparam logic [1:0] PIO_ADDR_DEF = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_WRITE,
    ST_READ,
    ST_CHECK
  } state_t;

endpackage

// File: rtl/ledtest_prescaler.sv
// Terminal-count prescaler: counts 0..PERIOD-1 while enabled.
// o_tick pulses combinationally in the terminal-count cycle.
module ledtest_prescaler #(
  parameter int unsigned PERIOD = 4
) (
  input  logic clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [31:0] TC = 32'(PERIOD - 1);

  logic [31:0] r_cnt;
  logic        w_tc;

  assign w_tc   = (r_cnt == TC);
  assign o_tick = i_en & w_tc;

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ledtest_pio_master.sv
// Avalon-MM master that blinks an LED through a PIO slave,
// reading each write back and flagging any disagreement.
module ledtest_pio_master
  import ledtest_pkg::*;
#(
  parameter int unsigned BLINK_PERIOD = 50000000,
  parameter logic [1:0]  PIO_ADDR     = PIO_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              led_state,
  output logic              mismatch,
  output logic [15:0]       toggle_count
);

  state_t              r_state;
  logic                r_pattern;
  logic                r_rd_bit;
  logic                r_cs;
  logic                r_write_n;
  logic                r_read_n;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_led;
  logic                r_mismatch;
  logic [15:0]         r_toggle_count;

  logic                w_tick;
  logic                w_ps_en;
  logic                w_ps_clr;
  logic [DATA_W-1:1]   w_unused_rd;

  assign w_unused_rd = avm_readdata[DATA_W-1:1];

  // Prescaler only runs while waiting; bus cycles freeze it.
  assign w_ps_en  = (r_state == ST_WAIT_TICK) & enable;
  assign w_ps_clr = (r_state == ST_IDLE)
                  | ((r_state == ST_WAIT_TICK) & ~enable);

  ledtest_prescaler #(
    .PERIOD (BLINK_PERIOD)
  ) u_prescaler (
    .clk       (clk),
    .i_reset_n (reset_n),
    .i_clr     (w_ps_clr),
    .i_en      (w_ps_en),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_pattern      <= 1'b0;
      r_rd_bit       <= 1'b0;
      r_cs           <= 1'b0;
      r_write_n      <= 1'b1;
      r_read_n       <= 1'b1;
      r_wdata        <= '0;
      r_led          <= 1'b0;
      r_mismatch     <= 1'b0;
      r_toggle_count <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_pattern <= ~r_pattern;
            r_cs      <= 1'b1;
            r_write_n <= 1'b0;
            r_wdata   <= {{(DATA_W-1){1'b0}}, ~r_pattern};
            r_state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!avm_waitrequest) begin
            r_led     <= r_pattern;
            r_write_n <= 1'b1;
            r_read_n  <= 1'b0;
            r_state   <= ST_READ;
          end
        end
        ST_READ: begin
          if (!avm_waitrequest) begin
            r_rd_bit <= avm_readdata[0];
            r_cs     <= 1'b0;
            r_read_n <= 1'b1;
            r_state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_rd_bit != r_pattern) r_mismatch <= 1'b1;
          r_toggle_count <= r_toggle_count + 16'd1;
          r_state <= enable ? ST_WAIT_TICK : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign avm_address    = PIO_ADDR;
  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_write_n;
  assign avm_read_n     = r_read_n;
  assign avm_writedata  = r_wdata;
  assign led_state      = r_led;
  assign mismatch       = r_mismatch;
  assign toggle_count   = r_toggle_count;

endmodule

// File: doc/ledtest_pio_master.md
LEDTEST_PIO_MASTER -- requirements
Module: ledtest_pio_master

Interface
REQ-001 Parameter BLINK_PERIOD, default 50000000: clk cycles between successive LED toggles; legal range 2 to 2^32-1.
REQ-002 Parameter PIO_ADDR, default 0: 2-bit register address written and read back on the PIO slave.
REQ-003 Port clk  input  1  single clock; all logic rises on posedge clk.
REQ-004 Port reset_n  input  1  reset, synchronous, active-low.
REQ-005 Port enable  input  1  high = run blink sequence; low = stop after the current transaction.
REQ-006 Port avm_address  output  2  Avalon-MM address to the PIO slave.
REQ-007 Port avm_chipselect  output  1  Avalon-MM select; high during any transfer.
REQ-008 Port avm_write_n  output  1  active-low write strobe.
REQ-009 Port avm_read_n  output  1  active-low read strobe.
REQ-010 Port avm_writedata  output  32  write data; bit 0 = LED value, bits 31:1 = 0.
REQ-011 Port avm_readdata  input  32  slave read data, valid in the cycle the read is accepted.
REQ-012 Port avm_waitrequest  input  1  slave stall; a transfer is accepted in a cycle where it is low.
REQ-013 Port led_state  output  1  last LED value successfully written.
REQ-014 Port mismatch  output  1  sticky flag: a readback differed from the written value.
REQ-015 Port toggle_count  output  16  number of completed write+readback cycles, wraps modulo 2^16.

Function
REQ-016 FSM states: IDLE, WAIT_TICK, WRITE, READ, CHECK.
REQ-017 IDLE: all strobes inactive, prescaler held at 0; enable=1 -> WAIT_TICK next cycle.
REQ-018 WAIT_TICK: prescaler counts 0..BLINK_PERIOD-1; at terminal count, prescaler -> 0, pattern bit inverts, go WRITE; enable=0 here -> IDLE, prescaler cleared.
REQ-019 WRITE: avm_chipselect=1, avm_write_n=0, avm_address=PIO_ADDR, avm_writedata={31'b0,pattern}; held stable while avm_waitrequest=1; on acceptance, led_state<=pattern, go READ.
REQ-020 READ: avm_chipselect=1, avm_read_n=0, avm_address=PIO_ADDR; held while avm_waitrequest=1; on acceptance, capture avm_readdata[0], go CHECK.
REQ-021 CHECK (one cycle, no strobes): if captured bit != pattern, mismatch<=1; toggle_count increments (0xFFFF -> 0x0000); then WAIT_TICK if enable=1 else IDLE.
REQ-022 enable falling during WRITE or READ does not abort; the transfer and CHECK complete first.
REQ-023 avm_write_n and avm_read_n never both low; strobes are registered outputs, glitch-free.
REQ-024 First toggle after enable rises occurs BLINK_PERIOD cycles after entering WAIT_TICK; with waitrequest=0 a full sequence (WRITE, READ, CHECK) takes 3 cycles and does not advance the prescaler.
REQ-025 mismatch clears only on reset.

Reset
REQ-026 While reset_n=0 at posedge clk: state=IDLE, prescaler=0, pattern=0, led_state=0, mismatch=0, toggle_count=0, avm_chipselect=0, avm_write_n=1, avm_read_n=1, avm_writedata=0, avm_address=PIO_ADDR.
REQ-027 Reset asserted mid-transfer drops strobes on the next edge; no completion is counted.

Structure
REQ-028 Shared package ledtest_pkg holds the FSM state enum, the PIO_ADDR default, and the 32-bit data width constant.
REQ-029 One sub-module, ledtest_prescaler (terminal-count counter with clear/enable, tick output), is instantiated; the FSM and Avalon drive stay in the top.

Verification (bench with BLINK_PERIOD=4, responsive PIO model)
REQ-030 Reset, enable=1, waitrequest=0 -> write of 0x00000001 accepted 4 cycles after WAIT_TICK entry; led_state=1; toggle_count=1; mismatch=0.
REQ-031 Waitrequest held high 3 cycles in WRITE -> address/writedata/strobes stable all 4 cycles; exactly one write accepted.
REQ-032 Model returns readdata=0 after writing 1 -> mismatch=1 after CHECK and stays 1 through later correct cycles.
REQ-033 enable dropped on the WRITE cycle with waitrequest=1 for 2 cycles -> write and read still complete, toggle_count increments, FSM reaches IDLE, no further strobes.
REQ-034 Force toggle_count to 0xFFFF via 65535 iterations (or fast preload) -> next CHECK yields 0x0000.
REQ-035 reset_n low during READ with waitrequest=1 -> next edge: strobes inactive, all outputs at REQ-026 values.
